// File: rtl/cmd_gather_pkg.sv
// Shared types and constants for the UART command assembler.
package cmd_gather_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_TIMEOUT_CLKS = 100000;
  localparam int BYTE_W           = 8;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchroniser, bit FSM and bit/clock counters.
// Strobes are combinational and fire in the cycle the stop bit is sampled.
module uart_rx_byte
  import cmd_gather_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  output logic              byte_valid_o,
  output logic [BYTE_W-1:0] byte_data_o,
  output logic              frame_err_o,
  output logic              idle_o,
  output logic              start_det_o
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [1:0]        sync_q;
  logic              prev_q;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic              rx_s;

  assign rx_s        = sync_q[1];
  assign byte_data_o = shreg_q;
  assign idle_o      = (state_q == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      prev_q    <= 1'b1;
      state_q   <= ST_IDLE;
      clk_cnt_q <= {CNT_W{1'b0}};
      bit_cnt_q <= 3'd0;
      shreg_q   <= {BYTE_W{1'b0}};
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      prev_q    <= sync_q[1];
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    start_det_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = {CNT_W{1'b0}};
        bit_cnt_d = 3'd0;
        if (prev_q && !rx_s) begin
          start_det_o = 1'b1;
          state_d     = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // Half-bit wait centres all later samples in their bit cells.
        if (clk_cnt_q == CNT_W'(HALF - 1)) begin
          clk_cnt_d = {CNT_W{1'b0}};
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = {CNT_W{1'b0}};
          shreg_d   = {rx_s, shreg_q[BYTE_W-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d    = {CNT_W{1'b0}};
          state_d      = ST_IDLE;
          byte_valid_o = rx_s;
          frame_err_o  = !rx_s;
        end else begin
          clk_cnt_d = clk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/cmd_assembler.sv
// Gathers received UART bytes into fixed-length command words, MSB first,
// and writes them to a downstream FIFO with timeout and overflow handling.
module cmd_assembler
  import cmd_gather_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CMD_BYTES    = 4,
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        uart_rx_in,
  input  logic                        cmd_fifo_full,
  output logic                        cmd_fifo_wr_en,
  output logic [BYTE_W*CMD_BYTES-1:0] cmd_fifo_wr_data,
  output logic                        frame_err,
  output logic                        timeout_err,
  output logic                        overflow_err,
  output logic [15:0]                 cmd_count
);

  localparam int WORD_W = BYTE_W * CMD_BYTES;
  localparam int CNT_W  = 5;
  localparam int TMO_W  = $clog2(TIMEOUT_CLKS) + 1;

  logic              byte_valid_s, rx_frame_err_s, rx_idle_s, start_det_s;
  logic [BYTE_W-1:0] byte_data_s;
  logic [WORD_W+BYTE_W-1:0] cat_s;
  logic [WORD_W-1:0] word_s;
  logic              tmo_run_s, tmo_exp_s;

  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0] gather_q, gather_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              wr_en_q, wr_en_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              frame_err_q, frame_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic              overflow_err_q, overflow_err_d;
  logic [15:0]       cmd_count_q, cmd_count_d;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (uart_rx_in),
    .byte_valid_o(byte_valid_s),
    .byte_data_o (byte_data_s),
    .frame_err_o (rx_frame_err_s),
    .idle_o      (rx_idle_s),
    .start_det_o (start_det_s)
  );

  // Appending below and truncating keeps the first byte at the top once full.
  assign cat_s     = {gather_q, byte_data_s};
  assign word_s    = cat_s[WORD_W-1:0];
  assign tmo_run_s = rx_idle_s && (byte_cnt_q != {CNT_W{1'b0}});
  assign tmo_exp_s = tmo_run_s && (tmo_q == TMO_W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q     <= {CNT_W{1'b0}};
      gather_q       <= {WORD_W{1'b0}};
      tmo_q          <= {TMO_W{1'b0}};
      wr_en_q        <= 1'b0;
      wr_data_q      <= {WORD_W{1'b0}};
      frame_err_q    <= 1'b0;
      timeout_err_q  <= 1'b0;
      overflow_err_q <= 1'b0;
      cmd_count_q    <= 16'd0;
    end else begin
      byte_cnt_q     <= byte_cnt_d;
      gather_q       <= gather_d;
      tmo_q          <= tmo_d;
      wr_en_q        <= wr_en_d;
      wr_data_q      <= wr_data_d;
      frame_err_q    <= frame_err_d;
      timeout_err_q  <= timeout_err_d;
      overflow_err_q <= overflow_err_d;
      cmd_count_q    <= cmd_count_d;
    end
  end

  always_comb begin
    byte_cnt_d     = byte_cnt_q;
    gather_d       = gather_q;
    tmo_d          = {TMO_W{1'b0}};
    wr_en_d        = 1'b0;
    wr_data_d      = wr_data_q;
    frame_err_d    = 1'b0;
    timeout_err_d  = 1'b0;
    overflow_err_d = 1'b0;
    cmd_count_d    = cmd_count_q;

    // Expiry wins over a simultaneous start bit; that byte then becomes byte 0.
    if (tmo_exp_s) begin
      timeout_err_d = 1'b1;
      byte_cnt_d    = {CNT_W{1'b0}};
    end else if (tmo_run_s && !start_det_s) begin
      tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_d = {TMO_W{1'b0}};
    end

    if (rx_frame_err_s) begin
      frame_err_d = 1'b1;
      byte_cnt_d  = {CNT_W{1'b0}};
    end else if (byte_valid_s) begin
      gather_d = word_s;
      if (byte_cnt_q == CNT_W'(CMD_BYTES - 1)) begin
        byte_cnt_d = {CNT_W{1'b0}};
        if (cmd_fifo_full) begin
          overflow_err_d = 1'b1;
        end else begin
          wr_en_d     = 1'b1;
          wr_data_d   = word_s;
          cmd_count_d = cmd_count_q + 16'd1;
        end
      end else begin
        byte_cnt_d = byte_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      gather_d = gather_q;
    end
  end

  assign cmd_fifo_wr_en   = wr_en_q;
  assign cmd_fifo_wr_data = wr_data_q;
  assign frame_err        = frame_err_q;
  assign timeout_err      = timeout_err_q;
  assign overflow_err     = overflow_err_q;
  assign cmd_count        = cmd_count_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// Directed bench for cmd_assembler with a fast UART bit time and short timeout.
module tb_cmd_assembler;

  localparam int CPB = 4;
  localparam int CB  = 4;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx_in = 1'b1;
  logic        cmd_fifo_full = 1'b0;
  logic        cmd_fifo_wr_en;
  logic [31:0] cmd_fifo_wr_data;
  logic        frame_err, timeout_err, overflow_err;
  logic [15:0] cmd_count;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0, fe_cnt = 0, to_cnt = 0, ov_cnt = 0;
  logic [31:0] wr_seen = 32'h0;
  int wr_b, fe_b, to_b, ov_b;

  cmd_assembler #(.CLKS_PER_BIT(CPB), .CMD_BYTES(CB), .TIMEOUT_CLKS(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .uart_rx_in      (uart_rx_in),
    .cmd_fifo_full   (cmd_fifo_full),
    .cmd_fifo_wr_en  (cmd_fifo_wr_en),
    .cmd_fifo_wr_data(cmd_fifo_wr_data),
    .frame_err       (frame_err),
    .timeout_err     (timeout_err),
    .overflow_err    (overflow_err),
    .cmd_count       (cmd_count)
  );

  always #5 clk = ~clk;

  // Pulse-cycle counters sampled away from the active edge.
  always @(negedge clk) begin
    if (cmd_fifo_wr_en) begin
      wr_cnt  = wr_cnt + 1;
      wr_seen = cmd_fifo_wr_data;
    end
    if (frame_err)    fe_cnt = fe_cnt + 1;
    if (timeout_err)  to_cnt = to_cnt + 1;
    if (overflow_err) ov_cnt = ov_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_b);
    uart_rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      tick(CPB);
    end
    uart_rx_in = stop_b;
    tick(CPB);
    uart_rx_in = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8],  1'b1);
    send_byte(w[7:0],   1'b1);
  endtask

  task automatic snap();
    wr_b = wr_cnt; fe_b = fe_cnt; to_b = to_cnt; ov_b = ov_cnt;
  endtask

  initial begin
    tick(4);
    check("rst_wr_en",    {31'd0, cmd_fifo_wr_en}, 32'd0);
    check("rst_wr_data",  cmd_fifo_wr_data, 32'h0000_0000);
    check("rst_count",    {16'd0, cmd_count}, 32'd0);
    check("rst_errs",     {29'd0, frame_err, timeout_err, overflow_err}, 32'd0);
    rst = 1'b0;
    tick(10);

    // Basic command
    snap();
    send_word(32'hDEAD_BEEF);
    tick(10);
    check("basic_wr_pulses", wr_cnt - wr_b, 32'd1);
    check("basic_data",      wr_seen, 32'hDEAD_BEEF);
    check("basic_count",     {16'd0, cmd_count}, 32'd1);
    check("basic_no_errs",   (fe_cnt - fe_b) + (to_cnt - to_b) + (ov_cnt - ov_b), 32'd0);
    tick(20);
    check("hold_data",       cmd_fifo_wr_data, 32'hDEAD_BEEF);

    // Timeout discards a partial command
    snap();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(250);
    check("tmo_pulse",       to_cnt - to_b, 32'd1);
    check("tmo_no_wr",       wr_cnt - wr_b, 32'd0);
    send_word(32'h3344_5566);
    tick(10);
    check("tmo_wr_pulses",   wr_cnt - wr_b, 32'd1);
    check("tmo_data",        wr_seen, 32'h3344_5566);
    check("tmo_count",       {16'd0, cmd_count}, 32'd2);

    // Gap shorter than the timeout keeps the partial command
    snap();
    send_byte(8'hC0, 1'b1);
    send_byte(8'hFF, 1'b1);
    tick(150);
    send_byte(8'hEE, 1'b1);
    send_byte(8'h01, 1'b1);
    tick(10);
    check("gap_no_tmo",      to_cnt - to_b, 32'd0);
    check("gap_data",        wr_seen, 32'hC0FF_EE01);
    check("gap_count",       {16'd0, cmd_count}, 32'd3);

    // Framing error discards partial data
    snap();
    send_byte(8'hA5, 1'b0);
    tick(8);
    check("fe_pulse",        fe_cnt - fe_b, 32'd1);
    send_word(32'h0102_0304);
    tick(10);
    check("fe_wr_pulses",    wr_cnt - wr_b, 32'd1);
    check("fe_data",         wr_seen, 32'h0102_0304);
    check("fe_count",        {16'd0, cmd_count}, 32'd4);

    // FIFO full at completion drops the word
    snap();
    cmd_fifo_full = 1'b1;
    send_word(32'h1234_5678);
    tick(10);
    check("ovf_pulse",       ov_cnt - ov_b, 32'd1);
    check("ovf_no_wr",       wr_cnt - wr_b, 32'd0);
    check("ovf_count",       {16'd0, cmd_count}, 32'd4);
    check("ovf_data_held",   cmd_fifo_wr_data, 32'h0102_0304);
    cmd_fifo_full = 1'b0;
    send_word(32'h9ABC_DEF0);
    tick(10);
    check("ovf_then_wr",     wr_cnt - wr_b, 32'd1);
    check("ovf_then_data",   wr_seen, 32'h9ABC_DEF0);
    check("ovf_then_count",  {16'd0, cmd_count}, 32'd5);

    // Short low glitch is a false start
    snap();
    uart_rx_in = 1'b0;
    tick(2);
    uart_rx_in = 1'b1;
    tick(20);
    check("glitch_no_fe",    fe_cnt - fe_b, 32'd0);
    check("glitch_no_wr",    wr_cnt - wr_b, 32'd0);
    send_word(32'h5566_7788);
    tick(10);
    check("glitch_then_data", wr_seen, 32'h5566_7788);
    check("glitch_then_count", {16'd0, cmd_count}, 32'd6);

    // Reset in the middle of the third byte
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    uart_rx_in = 1'b0;
    tick(CPB);
    uart_rx_in = 1'b1;
    tick(3 * CPB);
    rst = 1'b1;
    tick(3);
    check("mid_rst_count",   {16'd0, cmd_count}, 32'd0);
    check("mid_rst_data",    cmd_fifo_wr_data, 32'h0000_0000);
    rst = 1'b0;
    tick(10);
    snap();
    send_word(32'h0123_4567);
    tick(10);
    check("post_rst_wr",     wr_cnt - wr_b, 32'd1);
    check("post_rst_data",   wr_seen, 32'h0123_4567);
    check("post_rst_count",  {16'd0, cmd_count}, 32'd1);
    check("post_rst_no_fe",  fe_cnt - fe_b, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_assembler.md
CMD_ASSEMBLER -- requirements
Module: cmd_assembler

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud); legal range 4 or more.
REQ-002 Parameter CMD_BYTES, default 4, meaning bytes gathered per command word; legal range 1..16.
REQ-003 Parameter TIMEOUT_CLKS, default 100000, meaning idle clk cycles allowed between bytes of a partial command.
REQ-004 Port clk, input, 1, meaning the single system clock; all logic is synchronous to its rising edge.
REQ-005 Port rst, input, 1, meaning asynchronous, active-high reset.
REQ-006 Port uart_rx_in, input, 1, meaning asynchronous serial line, 8N1 format, idle high.
REQ-007 Port cmd_fifo_full, input, 1, meaning the downstream command FIFO cannot accept a write this cycle.
REQ-008 Port cmd_fifo_wr_en, output, 1, meaning one-cycle write strobe for a completed command.
REQ-009 Port cmd_fifo_wr_data, output, 8*CMD_BYTES, meaning the completed command word.
REQ-010 Port frame_err, output, 1, meaning one-cycle pulse on a stop bit sampled low.
REQ-011 Port timeout_err, output, 1, meaning one-cycle pulse when a partial command is discarded by timeout.
REQ-012 Port overflow_err, output, 1, meaning one-cycle pulse when a completed command is dropped because the FIFO is full.
REQ-013 Port cmd_count, output, 16, meaning count of commands written, wrapping.

Function
REQ-014 uart_rx_in SHALL pass through a 2-flop synchroniser whose flops reset to 1.
REQ-015 The RX FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-016 IDLE -> START on a synchronised falling edge.
REQ-017 START SHALL wait CLKS_PER_BIT/2 cycles, then sample; a low sample goes to DATA, a high sample is a false start and returns to IDLE with no error.
REQ-018 DATA SHALL sample every CLKS_PER_BIT cycles, 8 samples, LSB first.
REQ-019 STOP SHALL wait CLKS_PER_BIT cycles, then sample; high produces byte_valid, low produces frame_err; both then go to IDLE.
REQ-020 On byte_valid, the byte SHALL shift into the gather register and byte_cnt SHALL increment; the first received byte ends in bits [8*CMD_BYTES-1 -: 8] (MSB-first).
REQ-021 On byte_valid with byte_cnt==CMD_BYTES-1 and cmd_fifo_full=0, cmd_fifo_wr_en SHALL assert for exactly one cycle, on the cycle after the stop sample, and cmd_fifo_wr_data SHALL hold the word in that cycle; cmd_count SHALL increment.
REQ-022 In the same case with cmd_fifo_full=1, the word SHALL be dropped, overflow_err SHALL pulse, and there SHALL be no write; cmd_fifo_full is sampled only at completion.
REQ-023 On completion or drop, byte_cnt SHALL return to 0.
REQ-024 frame_err SHALL discard any partial command (byte_cnt SHALL go to 0).
REQ-025 The timeout counter SHALL run only while the FSM is in IDLE and byte_cnt!=0, and SHALL clear on every start-bit detection.
REQ-026 When the timeout counter reaches TIMEOUT_CLKS-1, timeout_err SHALL pulse and byte_cnt SHALL go to 0.
REQ-027 Timeout expiry coinciding with a falling edge: the timeout SHALL take effect, and the new byte SHALL be received as byte 0.
REQ-028 With CMD_BYTES=1, every valid byte is a complete command and no timeout can occur.
REQ-029 cmd_count SHALL wrap from 16'hFFFF to 0.
REQ-030 cmd_fifo_wr_data SHALL hold its last value between writes.

Reset
REQ-031 On rst=1, asynchronously: FSM=IDLE, synchroniser=1, byte_cnt=0, gather register=0, timeout counter=0, cmd_fifo_wr_en=0, cmd_fifo_wr_data=0, all error pulses=0, cmd_count=0.
REQ-032 Reset mid-byte or mid-command SHALL discard all partial data; after release, the first falling edge begins a fresh byte 0.

Structure
REQ-033 Package cmd_gather_pkg SHALL hold the RX state enum, the default CLKS_PER_BIT and TIMEOUT_CLKS constants, and the byte width constant (8).
REQ-034 Sub-module uart_rx_byte SHALL contain the synchroniser, the bit FSM and the bit counters, exposing byte_valid, byte_data and frame_err; cmd_assembler SHALL contain the gather, timeout and FIFO logic.

Verification (CLKS_PER_BIT=4, CMD_BYTES=4, TIMEOUT_CLKS=200)
REQ-035 Send bytes 0xDE, 0xAD, 0xBE, 0xEF back-to-back -> one wr_en pulse with data 0xDEADBEEF, and cmd_count=1.
REQ-036 Send 0x11, 0x22, then idle for 250 cycles, then send 0x33, 0x44, 0x55, 0x66 -> timeout_err pulses once, then a write of 0x33445566.
REQ-037 Send 0xA5 with its stop bit forced low, then 0x01, 0x02, 0x03, 0x04 -> frame_err pulses, then a write of 0x01020304.
REQ-038 Hold cmd_fifo_full=1 and send 4 bytes -> overflow_err pulses and no wr_en; release full and send 4 more bytes -> a normal write.
REQ-039 Issue a 2-cycle low glitch on the line -> false start, no error, no byte.
REQ-040 Assert rst during the 3rd byte, then send 4 bytes -> the write contains only the post-reset bytes, and cmd_count=1.
